// File: rtl/ifetch_ctrl_if.sv
// Instruction memory bus between the fetch controller
// and the combinational instruction memory.
interface ifetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills IF/ID,
// sequences stall/redirect and traps out-of-range fetches.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  ifetch_ctrl_if.master imem,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic {
    RUN,
    FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] faddr_q, faddr_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] cand;
  logic        redirect;
  logic        legal;

  // Branch is the older instruction, so it beats the jump.
  always_comb begin
    cand     = pc_q + 32'd4;
    redirect = branch_taken | jump;
    if (branch_taken)
      cand = branch_target;
    else if (jump)
      cand = {pc4_q[31:28], jump_index, 2'b00};
    else if (stall)
      cand = pc_q;
    legal = (cand[1:0] == 2'b00) && (cand <= LAST_ADDR);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    faddr_d = faddr_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (!legal) begin
          state_d = FAULT;
          fault_d = 1'b1;
          faddr_d = cand;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (redirect) begin
          pc_d    = cand;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_d    = cand;
          instr_d = imem.imem_rdata;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      FAULT: begin
        instr_d = '0;
        valid_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      faddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      faddr_q <= faddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign ifid_instr     = instr_q;
  assign ifid_pc4       = pc4_q;
  assign ifid_valid     = valid_q;
  assign fault          = fault_q;
  assign fault_addr     = faddr_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: a behavioural fetch model
// predicts each cycle, a monitor compares after every edge.
module tb_ifetch_ctrl;

  localparam int MB = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic [31:0] ifid_instr, ifid_pc4, fault_addr, fetch_count;
  logic        ifid_valid, fault;

  ifetch_ctrl_if bus ();

  ifetch_ctrl #(.RESET_PC(32'h0), .MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .imem(bus.master),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .fault(fault),
    .fault_addr(fault_addr), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [MB];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a <= 32'(MB - 4))
      return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    return 32'hDEAD_BEEF;
  endfunction

  always_comb bus.imem_rdata = rd(bus.imem_addr);

  typedef struct {
    int          cyc;
    logic [31:0] pc, instr, pc4, fa, cnt;
    logic        valid, flt;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_fa, m_cnt;
  logic        m_valid, m_flt;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("imem_addr", bus.imem_addr, e.pc);
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_pc4", ifid_pc4, e.pc4);
        chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
        chk("fault", 32'(fault), 32'(e.flt));
        chk("fault_addr", fault_addr, e.fa);
        chk("fetch_count", fetch_count, e.cnt);
      end
    end
  end

  task automatic step(input bit rst_n, input bit st, input bit br,
                      input logic [31:0] tgt, input bit j,
                      input logic [25:0] idx);
    logic [31:0] nxt;
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_n; stall = st; branch_taken = br;
    branch_target = tgt; jump = j; jump_index = idx;
    if (!rst_n) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_flt = 0; m_fa = 0; m_cnt = 0;
    end else if (!m_flt) begin
      if (br) nxt = tgt;
      else if (j) nxt = {m_pc4[31:28], idx, 2'b00};
      else if (st) nxt = m_pc;
      else nxt = m_pc + 4;
      if (nxt % 4 != 0 || nxt > MB - 4) begin
        m_flt = 1; m_fa = nxt; m_instr = 0; m_valid = 0;
      end else if (br || j) begin
        m_pc = nxt; m_instr = 0; m_valid = 0;
      end else if (!st) begin
        m_instr = rd(m_pc); m_pc4 = m_pc + 4;
        m_valid = 1; m_cnt = m_cnt + 1; m_pc = nxt;
      end
    end
    e.cyc = cyc + 1;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.flt = m_flt; e.fa = m_fa; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic run(); step(1, 0, 0, 0, 0, 0); endtask

  initial begin : driver
    logic [31:0] tgt;
    bit r, s, b, j;
    for (int i = 0; i < MB; i++) mem[i] = 8'($urandom);
    {mem[0], mem[1], mem[2], mem[3]} = 32'h0001_1020;
    {mem[4], mem[5], mem[6], mem[7]} = 32'h0002_1820;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_flt = 0; m_fa = 0; m_cnt = 0;

    step(0, 0, 0, 0, 0, 0);
    run(); run(); run();
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    run();
    step(1, 1, 1, 32'h14, 0, 0);
    run();
    step(1, 0, 1, 32'h20, 0, 0);
    run();
    step(1, 0, 0, 0, 1, 26'h2);
    run();
    step(1, 0, 1, 32'h10, 1, 26'h2);
    run();
    step(1, 0, 1, 32'h13, 0, 0);
    run(); step(1, 1, 1, 32'h8, 1, 26'h1);
    step(0, 1, 1, 32'h8, 0, 0);
    run();
    step(1, 0, 1, 32'h7C, 0, 0);
    run(); run();
    step(0, 0, 0, 0, 0, 0);
    run(); run();

    for (int i = 0; i < 400; i++) begin
      r = m_flt ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 40) != 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      j = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 4) != 0)
        tgt = 32'($urandom_range(0, MB / 4 - 1)) << 2;
      else
        tgt = 32'($urandom_range(0, MB + 16));
      step(r, s, b, tgt, j, 26'($urandom_range(0, 40)));
    end

    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, need 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller for the 5-stage MIPS pipeline. It owns the program counter and drives the address of the combinational, byte-addressed, big-endian instruction memory. It also registers the fetched word into the IF/ID pipeline register. Stall, branch and jump redirection, and out-of-range fetch protection are sequenced here, so the memory itself stays a pure lookup.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; word-aligned.
- MEM_BYTES, 128, instruction memory size in bytes; multiple of 4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- stall  in  1  load-use hazard hold from the hazard unit
- branch_taken  in  1  taken branch resolved this cycle
- branch_target  in  32  absolute byte target of the branch
- jump  in  1  J-type instruction decoded in ID this cycle
- jump_index  in  26  instr[25:0] of that jump
- imem_addr  out  32  byte address to instruction memory (= pc)
- imem_rdata  in  32  instruction word returned combinationally
- ifid_instr  out  32  IF/ID instruction register
- ifid_pc4  out  32  IF/ID PC+4 register
- ifid_valid  out  1  IF/ID holds a real instruction
- fault  out  1  sticky fetch-fault flag
- fault_addr  out  32  offending address captured on fault
- fetch_count  out  32  number of instructions accepted into IF/ID

## Operation
- Two states: RUN and FAULT. Reset (reset==0 at a clock edge) forces RUN.
- Reset values: pc=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, fault=0, fault_addr=0, fetch_count=0.
- imem_addr = pc at all times, including in FAULT.
- Candidate next PC in RUN, highest priority first:
  - branch_taken: branch_target.
  - jump: {ifid_pc4[31:28], jump_index, 2'b00}.
  - stall: pc.
  - else: pc+4.
- branch_taken beats jump because the branch is the older instruction.
- A redirect (branch_taken or jump) overrides stall.
- Legal address: bits[1:0]==0 and address <= MEM_BYTES-4. All arithmetic is 32-bit unsigned with wrap.
- RUN, legal candidate:
  - Redirect: pc<=candidate; IF/ID flushed (ifid_instr<=0, i.e. nop; ifid_valid<=0). ifid_pc4 is not updated; it keeps its old value.
  - Stall only: pc, ifid_instr, ifid_pc4 and ifid_valid all hold.
  - Normal: ifid_instr<=imem_rdata, ifid_pc4<=pc+4, ifid_valid<=1, fetch_count<=fetch_count+1 (wraps).
- RUN, illegal candidate:
  - Go to FAULT: fault<=1, fault_addr<=candidate, pc holds, IF/ID flushed.
  - This applies to redirects and to sequential run-off past the end of memory.
- FAULT:
  - All inputs are ignored.
  - pc and fetch_count hold; ifid_valid=0 and ifid_instr=0.
  - Left only by reset.
- fetch_count never counts stalled, flushed or faulted cycles.

## Timing
- Fetch latency: 1 cycle. The word at pc is visible in ifid_instr after the next rising edge.
- Redirect penalty: exactly one bubble.
  - Edge N: the redirect is sampled and the bubble enters IF/ID.
  - Edge N+1: the target instruction enters IF/ID.
- stall, branch_taken and jump are sampled only at the rising edge; there is no combinational path from them to imem_addr.
- Reset mid-stall or mid-redirect: reset wins at that edge; all registers take reset values.
- Fault is flagged at the same edge the illegal candidate would have been loaded.
- The redirect sampled at that edge is lost.

## Test plan
- Sequential fetch: memory words 0x00011020 at 0x0, 0x00021820 at 0x4. Release reset -> ifid_instr=0x00011020, ifid_pc4=4 after edge 1; ifid_instr=0x00021820, ifid_pc4=8 after edge 2; fetch_count=2.
- Stall: assert stall for 2 cycles with pc=0xC -> pc stays 0xC, IF/ID unchanged, fetch_count unchanged. Deassert -> fetch resumes at 0xC.
- Branch with simultaneous stall: branch_taken=1, branch_target=0x14, stall=1 at pc=0x14 region -> next pc=0x14, ifid_valid=0, ifid_instr=0. One edge later IF/ID holds the word at 0x14.
- Jump: ifid_pc4=0x24, jump=1, jump_index=26'h2 -> pc=0x8, one bubble.
- Jump and branch together: jump_index=26'h2 with branch_taken=1, branch_target=0x10 -> pc=0x10.
- Faults:
  - branch_target=0x13 -> fault=1, fault_addr=0x13, pc held, ifid_valid=0 thereafter.
  - Sequential fetch past 0x7C with MEM_BYTES=128 -> fault_addr=0x80.
  - After either fault, reset low for one edge -> all outputs back to reset values and fetch restarts at RESET_PC.
